// File: rtl/cache_pkg.sv
// Definitions shared between the line responder and the cache controller:
// line geometry defaults and the request-type encoding.
package cache_pkg;

  localparam int unsigned WORDS_PER_LINE_DFLT = 8;
  localparam int unsigned WORD_BYTES          = 4;
  localparam int unsigned LINE_OFFSET_BITS    = $clog2(WORDS_PER_LINE_DFLT) + $clog2(WORD_BYTES);

  typedef enum logic {
    REFILL    = 1'b0,
    WRITEBACK = 1'b1
  } req_type_e;

  // Clears the byte-within-line bits of an address.
  function automatic logic [31:0] line_base(input logic [31:0] addr,
                                            input int unsigned offset_bits);
    logic [31:0] mask;
    mask = '1;
    mask = mask << offset_bits;
    return addr & mask;
  endfunction

endpackage

// File: rtl/line_beat_counter.sv
// Loadable saturating counter with terminal-count flag; counts up to all-ones
// (beat counting) or down to zero (wait-state counting).
module line_beat_counter #(
  parameter int unsigned WIDTH    = 3,
  parameter bit          COUNT_UP = 1'b1
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  assign tc = COUNT_UP ? (count == '1) : (count == '0);

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && !tc) begin
      count <= COUNT_UP ? count + WIDTH'(1) : count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/mem_line_responder.sv
// Backing-memory side of a cache line transfer: serves refills as back-to-back
// read beats and write-backs as flow-controlled write beats after a fixed latency.
module mem_line_responder
  import cache_pkg::*;
#(
  parameter int unsigned WORDS_PER_LINE = WORDS_PER_LINE_DFLT,
  parameter int unsigned LATENCY        = 4
) (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] wdata,
  input  logic        wvalid,
  output logic        wready,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        cache_ready,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic        mem_rden,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned BEAT_W    = $clog2(WORDS_PER_LINE);
  localparam int unsigned OFS_BITS  = BEAT_W + $clog2(WORD_BYTES);
  localparam logic [3:0]  WAIT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RD_BURST,
    RD_DRAIN,
    WR_BURST,
    DONE
  } state_e;

  state_e      state, state_nx;
  req_type_e   req_type;
  logic [31:0] base;
  logic        rd_pend;
  logic        accept;

  logic [BEAT_W-1:0] beat;
  logic              beat_last, beat_load, beat_en;
  logic [3:0]        wait_cnt_unused;
  logic              wait_zero, wait_en;

  assign accept = (state == IDLE) && req_valid;

  line_beat_counter #(
    .WIDTH   (4),
    .COUNT_UP(1'b0)
  ) u_wait_cnt (
    .CLK       (CLK),
    .reset_n   (reset_n),
    .load      (accept),
    .load_value(WAIT_LOAD),
    .en        (wait_en),
    .count     (wait_cnt_unused),
    .tc        (wait_zero)
  );

  line_beat_counter #(
    .WIDTH   (BEAT_W),
    .COUNT_UP(1'b1)
  ) u_beat_cnt (
    .CLK       (CLK),
    .reset_n   (reset_n),
    .load      (beat_load),
    .load_value('0),
    .en        (beat_en),
    .count     (beat),
    .tc        (beat_last)
  );

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      base     <= '0;
      req_type <= REFILL;
      rd_pend  <= 1'b0;
    end else begin
      state   <= state_nx;
      rd_pend <= mem_rden;
      if (accept) begin
        base     <= line_base(req_addr, OFS_BITS);
        req_type <= req_type_e'(req_we);
      end
    end
  end

  always_comb begin
    state_nx    = state;
    mem_rden    = 1'b0;
    mem_wen     = 1'b0;
    wready      = 1'b0;
    cache_ready = 1'b0;
    beat_en     = 1'b0;
    wait_en     = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          // With zero latency the request type is taken straight from the port,
          // since the latched copy only lands on this same edge.
          if (LATENCY == 0) state_nx = req_we ? WR_BURST : RD_BURST;
          else              state_nx = WAIT;
        end
      end
      WAIT: begin
        wait_en = 1'b1;
        if (wait_zero) state_nx = (req_type == REFILL) ? RD_BURST : WR_BURST;
      end
      RD_BURST: begin
        mem_rden = 1'b1;
        beat_en  = 1'b1;
        if (beat_last) state_nx = RD_DRAIN;
      end
      RD_DRAIN: begin
        state_nx = DONE;
      end
      WR_BURST: begin
        wready = 1'b1;
        if (wvalid) begin
          mem_wen = 1'b1;
          beat_en = 1'b1;
          if (beat_last) state_nx = DONE;
        end
      end
      DONE: begin
        cache_ready = 1'b1;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign beat_load = ((state_nx == RD_BURST) || (state_nx == WR_BURST)) &&
                     !((state == RD_BURST) || (state == WR_BURST));

  // Gated by reset_n so the handshake reads 0 while reset is held.
  assign req_ready = reset_n && (state == IDLE);
  assign busy      = (state != IDLE);
  assign mem_addr  = base + {{(32 - BEAT_W - 2){1'b0}}, beat, 2'b00};
  assign mem_wdata = mem_wen ? wdata : '0;
  assign rvalid    = rd_pend;
  assign rdata     = rd_pend ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder: a LATENCY=4 instance and a LATENCY=0
// instance, each backed by a one-cycle-latency RAM returning addr ^ A5A5_0000.
module tb_mem_line_responder;

  logic        CLK = 1'b0;
  logic        reset_n;
  logic        req_valid, req_valid_z;
  logic        req_we;
  logic [31:0] req_addr, wdata;
  logic        wvalid;

  logic        req_ready, wready, rvalid, cache_ready, busy, mem_rden, mem_wen;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  logic        req_ready_z, wready_z, rvalid_z, cache_ready_z, busy_z, mem_rden_z, mem_wen_z;
  logic [31:0] rdata_z, mem_addr_z, mem_wdata_z, mem_rdata_z;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  mem_line_responder #(.WORDS_PER_LINE(8), .LATENCY(4)) dut (
    .CLK(CLK), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .wdata(wdata), .wvalid(wvalid),
    .wready(wready), .rdata(rdata), .rvalid(rvalid), .cache_ready(cache_ready),
    .busy(busy), .mem_addr(mem_addr), .mem_rden(mem_rden), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_line_responder #(.WORDS_PER_LINE(8), .LATENCY(0)) dut_z (
    .CLK(CLK), .reset_n(reset_n), .req_valid(req_valid_z), .req_ready(req_ready_z),
    .req_we(req_we), .req_addr(req_addr), .wdata(wdata), .wvalid(wvalid),
    .wready(wready_z), .rdata(rdata_z), .rvalid(rvalid_z), .cache_ready(cache_ready_z),
    .busy(busy_z), .mem_addr(mem_addr_z), .mem_rden(mem_rden_z), .mem_wen(mem_wen_z),
    .mem_wdata(mem_wdata_z), .mem_rdata(mem_rdata_z)
  );

  always @(posedge CLK) begin
    if (mem_rden)   mem_rdata   <= mem_addr   ^ 32'hA5A5_0000;
    if (mem_rden_z) mem_rdata_z <= mem_addr_z ^ 32'hA5A5_0000;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int nwen;
    int seen_cr;
    logic wv;
    logic exp_wr, exp_wen;

    reset_n = 1'b0; req_valid = 1'b0; req_valid_z = 1'b0; req_we = 1'b0;
    req_addr = '0; wdata = '0; wvalid = 1'b0;

    // Reset state
    #3;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_mem_addr",  mem_addr,       32'd0);
    chk("rst_rvalid",    32'(rvalid),    32'd0);
    @(negedge CLK); reset_n = 1'b1;
    @(negedge CLK); #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    // Refill, LATENCY=4, addr 0x1234 -> line 0x1220
    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_1234;
    #1;
    chk("rf_accept_ready", 32'(req_ready), 32'd1);
    for (int k = 1; k <= 15; k++) begin
      @(negedge CLK);
      if (k == 1) req_valid = 1'b0;
      #1;
      chk("rf_busy",   32'(busy),     32'(k <= 14));
      chk("rf_rden",   32'(mem_rden), 32'(k >= 5 && k <= 12));
      if (k >= 5 && k <= 12) chk("rf_addr", mem_addr, 32'h0000_1220 + 32'(4 * (k - 5)));
      chk("rf_rvalid", 32'(rvalid),   32'(k >= 6 && k <= 13));
      if (k >= 6 && k <= 13) chk("rf_rdata", rdata, 32'hA5A5_1220 + 32'(4 * (k - 6)));
      chk("rf_cready", 32'(cache_ready), 32'(k == 14));
      chk("rf_ready",  32'(req_ready),   32'(k == 15));
      chk("rf_wen",    32'(mem_wen),     32'd0);
    end

    // Write-back to 0x40 with stalls ahead of beats 2 and 5; stray wvalid in WAIT
    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0040;
    #1;
    nwen = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge CLK);
      if (k == 1) req_valid = 1'b0;
      wv = (k == 3) || (k inside {5, 6, 8, 9, 10, 12, 13, 14});
      wvalid = wv;
      wdata  = 32'hD000_0000 | 32'(k);
      #1;
      exp_wr  = (k >= 5 && k <= 14);
      exp_wen = exp_wr && wv;
      chk("wb_wready", 32'(wready),  32'(exp_wr));
      chk("wb_wen",    32'(mem_wen), 32'(exp_wen));
      chk("wb_rden",   32'(mem_rden), 32'd0);
      if (exp_wen) begin
        chk("wb_addr",  mem_addr,  32'h0000_0040 + 32'(4 * nwen));
        chk("wb_wdata", mem_wdata, 32'hD000_0000 | 32'(k));
      end
      if (mem_wen) nwen++;
      chk("wb_cready", 32'(cache_ready), 32'(k == 15));
      chk("wb_ready",  32'(req_ready),   32'(k == 16));
    end
    wvalid = 1'b0;
    chk("wb_nwrites", 32'(nwen), 32'd8);

    // wvalid in IDLE, then req_valid held through a refill with wvalid high
    @(negedge CLK);
    wvalid = 1'b1; wdata = 32'h0000_0BAD;
    #1;
    chk("idle_wen",    32'(mem_wen), 32'd0);
    chk("idle_wready", 32'(wready),  32'd0);
    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_2000;
    #1;
    chk("hold_accept", 32'(req_ready), 32'd1);
    for (int k = 1; k <= 23; k++) begin
      @(negedge CLK);
      if (k == 16) req_valid = 1'b0;
      #1;
      chk("hold_wen",    32'(mem_wen),     32'd0);
      chk("hold_ready",  32'(req_ready),   32'(k == 15));
      chk("hold_cready", 32'(cache_ready), 32'(k == 14));
      chk("hold_busy",   32'(busy),        32'(k != 15));
      chk("hold_rden",   32'(mem_rden),    32'((k >= 5 && k <= 12) || k >= 20));
      if (k >= 20) chk("hold_addr2", mem_addr, 32'h0000_2000 + 32'(4 * (k - 20)));
    end

    // Second refill is issuing beat 3: pulse reset
    reset_n = 1'b0;
    #1;
    chk("ar_req_ready",   32'(req_ready),   32'd0);
    chk("ar_busy",        32'(busy),        32'd0);
    chk("ar_rvalid",      32'(rvalid),      32'd0);
    chk("ar_wready",      32'(wready),      32'd0);
    chk("ar_cache_ready", 32'(cache_ready), 32'd0);
    chk("ar_mem_rden",    32'(mem_rden),    32'd0);
    chk("ar_mem_wen",     32'(mem_wen),     32'd0);
    chk("ar_mem_addr",    mem_addr,         32'd0);
    chk("ar_mem_wdata",   mem_wdata,        32'd0);
    chk("ar_rdata",       rdata,            32'd0);
    @(negedge CLK);
    reset_n = 1'b1;
    #1;
    chk("ar_release_ready", 32'(req_ready), 32'd1);
    chk("ar_release_busy",  32'(busy),      32'd0);
    seen_cr = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK); #1;
      if (cache_ready) seen_cr++;
    end
    chk("ar_no_cready", 32'(seen_cr), 32'd0);
    wvalid = 1'b0;

    // LATENCY=0 refill at 0x104 -> line 0x100
    @(negedge CLK);
    req_valid_z = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0104;
    #1;
    chk("z_accept_ready", 32'(req_ready_z), 32'd1);
    for (int k = 1; k <= 11; k++) begin
      @(negedge CLK);
      if (k == 1) req_valid_z = 1'b0;
      #1;
      chk("z_rden",   32'(mem_rden_z), 32'(k >= 1 && k <= 8));
      if (k <= 8) chk("z_addr", mem_addr_z, 32'h0000_0100 + 32'(4 * (k - 1)));
      chk("z_rvalid", 32'(rvalid_z),   32'(k >= 2 && k <= 9));
      if (k >= 2 && k <= 9) chk("z_rdata", rdata_z, 32'hA5A5_0100 + 32'(4 * (k - 2)));
      chk("z_cready", 32'(cache_ready_z), 32'(k == 10));
      chk("z_ready",  32'(req_ready_z),   32'(k == 11));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
